// File: rtl/sram_pkg.sv
// Shared definitions for the dual async-SRAM controller: FSM encoding,
// chip-select bit position and default timing.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_SETUP,
        RD_WAIT,
        DONE
    } state_t;

    localparam int SRAM_SEL_BIT  = 16;
    localparam int WORD_W        = 16;
    localparam int DEF_ADDR_W    = 18;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_WE_CYCLES = 2;
    localparam int DEF_RD_CYCLES = 2;

    // Wait counter must hold the larger of the two strobe lengths.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sram_port.sv
// One SRAM chip interface: registered active-low strobes and address,
// tri-state write driver, and the raw bus seen by the read capture.
module sram_port
    import sram_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              rd,
    input  logic              strobe,
    input  logic              drive,
    input  logic [WORD_W-1:0] word,
    input  logic [DATA_W-1:0] wdata,
    output logic              ram_en,
    output logic              ram_oe,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    inout  wire  [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] bus
);

    logic              drv;
    logic [DATA_W-1:0] wd;

    // Every pin comes straight from a flop so strobes cannot glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en   <= 1'b1;
            ram_oe   <= 1'b1;
            ram_we   <= 1'b1;
            ram_addr <= '0;
            drv      <= 1'b0;
            wd       <= '0;
        end else begin
            ram_en <= ~sel;
            ram_oe <= ~(sel & rd);
            ram_we <= ~(sel & strobe);
            drv    <= sel & drive;
            if (sel)
                ram_addr <= {{(ADDR_W-WORD_W){1'b0}}, word};
            if (sel && drive)
                wd <= wdata;
        end
    end

    assign ram_data = drv ? wd : {DATA_W{1'bz}};
    assign bus      = ram_data;

endmodule

// File: rtl/sram_dual_ctrl.sv
// Request/acknowledge controller for two async SRAMs: one FSM and wait
// counter sequence whichever chip addr[16] selects.
module sram_dual_ctrl
    import sram_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int WE_CYCLES = DEF_WE_CYCLES,
    parameter int RD_CYCLES = DEF_RD_CYCLES
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  re,
    input  logic                  we,
    input  logic [SRAM_SEL_BIT:0] addr,
    input  logic [DATA_W-1:0]     data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  done,
    output logic                  busy,
    output logic                  ram1EN,
    output logic                  ram1OE,
    output logic                  ram1WE,
    output logic [ADDR_W-1:0]     ram_addr1,
    inout  wire  [DATA_W-1:0]     ram_data1,
    output logic                  ram2EN,
    output logic                  ram2OE,
    output logic                  ram2WE,
    output logic [ADDR_W-1:0]     ram_addr2,
    inout  wire  [DATA_W-1:0]     ram_data2
);

    localparam int CNT_W = cnt_width(WE_CYCLES, RD_CYCLES);

    state_t             state, nstate;
    logic [CNT_W-1:0]   cnt;
    logic               armed;
    logic               accept;
    logic               capture;
    logic               chip;
    logic [WORD_W-1:0]  word;
    logic [DATA_W-1:0]  wdata;
    logic               n_chip;
    logic [WORD_W-1:0]  n_word;
    logic [DATA_W-1:0]  n_wdata;
    logic               n_act;
    logic               n_rd;
    logic               n_strobe;
    logic               n_drive;
    logic [DATA_W-1:0]  bus1;
    logic [DATA_W-1:0]  bus2;

    assign accept  = (state == IDLE) && en && armed && (we || re);
    assign capture = (state == RD_WAIT) && en && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= nstate;
    end

    // RD_WAIT runs RD_CYCLES+1 cycles so a read completes with the same
    // accept-to-done latency (+2 over the strobe length) as a write.
    always_comb begin
        nstate = state;
        case (state)
            IDLE:      if (accept) nstate = we ? WR_SETUP : RD_SETUP;
            WR_SETUP:  nstate = WR_STROBE;
            WR_STROBE: if (cnt == '0) nstate = WR_HOLD;
            WR_HOLD:   nstate = DONE;
            RD_SETUP:  nstate = RD_WAIT;
            RD_WAIT:   if (cnt == '0) nstate = DONE;
            DONE:      nstate = IDLE;
            default:   nstate = IDLE;
        endcase
        if (!en) nstate = IDLE;
    end

    // Pin values are computed for the coming state and registered in the ports.
    always_comb begin
        n_chip   = chip;
        n_word   = word;
        n_wdata  = wdata;
        n_act    = 1'b0;
        n_rd     = 1'b0;
        n_strobe = 1'b0;
        n_drive  = 1'b0;
        if (accept) begin
            n_chip  = addr[SRAM_SEL_BIT];
            n_word  = addr[WORD_W-1:0];
            n_wdata = data_in;
        end
        case (nstate)
            WR_SETUP, WR_HOLD: begin
                n_act   = 1'b1;
                n_drive = 1'b1;
            end
            WR_STROBE: begin
                n_act    = 1'b1;
                n_drive  = 1'b1;
                n_strobe = 1'b1;
            end
            RD_SETUP, RD_WAIT: begin
                n_act = 1'b1;
                n_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed    <= 1'b1;
            chip     <= 1'b0;
            word     <= '0;
            wdata    <= '0;
            cnt      <= '0;
            data_out <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            // A held request must drop before it can be taken again.
            if (accept)          armed <= 1'b0;
            else if (!re && !we) armed <= 1'b1;
            chip  <= n_chip;
            word  <= n_word;
            wdata <= n_wdata;
            case (state)
                WR_SETUP: cnt <= CNT_W'(WE_CYCLES - 1);
                RD_SETUP: cnt <= CNT_W'(RD_CYCLES);
                default:  if (cnt != '0) cnt <= cnt - CNT_W'(1);
            endcase
            if (capture)
                data_out <= chip ? bus2 : bus1;
            done <= (nstate == DONE);
            busy <= (nstate != IDLE);
        end
    end

    sram_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram1 (
        .clk      (clk),
        .rst      (rst),
        .sel      (n_act && !n_chip),
        .rd       (n_rd),
        .strobe   (n_strobe),
        .drive    (n_drive),
        .word     (n_word),
        .wdata    (n_wdata),
        .ram_en   (ram1EN),
        .ram_oe   (ram1OE),
        .ram_we   (ram1WE),
        .ram_addr (ram_addr1),
        .ram_data (ram_data1),
        .bus      (bus1)
    );

    sram_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram2 (
        .clk      (clk),
        .rst      (rst),
        .sel      (n_act && n_chip),
        .rd       (n_rd),
        .strobe   (n_strobe),
        .drive    (n_drive),
        .word     (n_word),
        .wdata    (n_wdata),
        .ram_en   (ram2EN),
        .ram_oe   (ram2OE),
        .ram_we   (ram2WE),
        .ram_addr (ram_addr2),
        .ram_data (ram_data2),
        .bus      (bus2)
    );

endmodule

// File: tb/tb_sram_dual_ctrl.sv
// Scoreboard bench for sram_dual_ctrl with behavioural models of both SRAMs.
module tb_sram_dual_ctrl;

    localparam int LAT = 4;

    logic        clk, rst, en, re, we;
    logic [16:0] addr;
    logic [15:0] data_in, data_out;
    logic        done, busy;
    logic        ram1EN, ram1OE, ram1WE, ram2EN, ram2OE, ram2WE;
    logic [17:0] ram_addr1, ram_addr2;
    wire  [15:0] ram_data1, ram_data2;

    sram_dual_ctrl dut (
        .clk(clk), .rst(rst), .en(en), .re(re), .we(we), .addr(addr),
        .data_in(data_in), .data_out(data_out), .done(done), .busy(busy),
        .ram1EN(ram1EN), .ram1OE(ram1OE), .ram1WE(ram1WE),
        .ram_addr1(ram_addr1), .ram_data1(ram_data1),
        .ram2EN(ram2EN), .ram2OE(ram2OE), .ram2WE(ram2WE),
        .ram_addr2(ram_addr2), .ram_data2(ram_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] mem1 [256] = '{default: 16'h0000};
    logic [15:0] mem2 [256] = '{5: 16'h1234, default: 16'h0000};

    assign ram_data1 = (!ram1EN && !ram1OE) ? mem1[ram_addr1[7:0]] : 16'hzzzz;
    assign ram_data2 = (!ram2EN && !ram2OE) ? mem2[ram_addr2[7:0]] : 16'hzzzz;

    typedef struct { logic [15:0] data; int cyc; } exp_t;
    exp_t q[$];

    int errors = 0, checks = 0, cyc = 0;
    logic [15:0] last_rd;
    logic [17:0] cur_addr;

    // per-cycle event counters (written only by the monitor) and snapshots
    localparam int C_EN1 = 0, C_WE1 = 1, C_OE1 = 2, C_EN2 = 3, C_WE2 = 4,
                   C_OE2 = 5, C_A5 = 6, C_ADR = 7, C_VIOL = 8, C_ZBAD = 9, C_DONE = 10;
    int cnt [11] = '{default: 0};
    int base[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int d(input int i);
        return cnt[i] - base[i];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM write model plus pin monitor and scoreboard pop
    always @(negedge clk) begin
        if (!ram1EN && !ram1WE) mem1[ram_addr1[7:0]] = ram_data1;
        if (!ram2EN && !ram2WE) mem2[ram_addr2[7:0]] = ram_data2;
        if (!ram1EN) cnt[C_EN1]++;
        if (!ram1WE) cnt[C_WE1]++;
        if (!ram1OE) cnt[C_OE1]++;
        if (!ram2EN) cnt[C_EN2]++;
        if (!ram2WE) cnt[C_WE2]++;
        if (!ram2OE) cnt[C_OE2]++;
        if (!ram1EN && ram1OE && ram_data1 === 16'hA5A5) cnt[C_A5]++;
        if ((!ram1EN && ram_addr1 !== cur_addr) || (!ram2EN && ram_addr2 !== cur_addr)) cnt[C_ADR]++;
        if ((!ram1WE && !ram1OE) || (!ram2WE && !ram2OE)) cnt[C_VIOL]++;
        if ((ram1EN && ram_data1 !== 16'hzzzz) || (ram2EN && ram_data2 !== 16'hzzzz)) cnt[C_ZBAD]++;
        if (rst && done) begin
            exp_t e;
            cnt[C_DONE]++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done=1 with no pending request (cycle %0d)", cyc);
            end else begin
                e = q.pop_front();
                check("done_latency", cyc, e.cyc);
                check("data_out", {16'h0, data_out}, {16'h0, e.data});
            end
        end
    end

    task automatic snap();
        for (int i = 0; i < 11; i++) base[i] = cnt[i];
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", {31'h0, busy}, 32'h0);
    endtask

    // Present one request, let it be accepted, then drop it.
    task automatic issue(input bit wr, input logic [16:0] a, input logic [15:0] dat,
                         input logic [15:0] exp_rd, input bit push);
        exp_t e;
        @(negedge clk);
        cur_addr = {2'b00, a[15:0]};
        we = wr; re = !wr; addr = a; data_in = dat;
        @(posedge clk); #1;
        check("busy_after_accept", {31'h0, busy}, 32'h1);
        if (push) begin
            if (!wr) last_rd = exp_rd;
            e.data = last_rd;
            e.cyc  = cyc + LAT;
            q.push_back(e);
        end
        we = 1'b0; re = 1'b0;
    endtask

    task automatic op(input bit wr, input logic [16:0] a, input logic [15:0] dat, input logic [15:0] exp_rd);
        issue(wr, a, dat, exp_rd, 1'b1);
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; en = 1'b1; re = 1'b0; we = 1'b0; addr = '0; data_in = '0;
        last_rd = '0; cur_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_ram1_strobes", {29'h0, ram1EN, ram1OE, ram1WE}, 32'h7);
        check("rst_ram2_strobes", {29'h0, ram2EN, ram2OE, ram2WE}, 32'h7);
        check("rst_addrs", {ram_addr1[15:0], ram_addr2[15:0]}, 32'h0);
        check("rst_bus_z", {30'h0, ram_data1 === 16'hzzzz, ram_data2 === 16'hzzzz}, 32'h3);
        check("rst_outs", {data_out, 14'h0, done, busy}, 32'h0);
        rst = 1'b1;

        // single write to RAM1
        snap();
        op(1'b1, 17'h00005, 16'hA5A5, 16'h0);
        check("wr_we1_low_cycles", d(C_WE1), 2);
        check("wr_en1_low_cycles", d(C_EN1), 4);
        check("wr_oe1_low_cycles", d(C_OE1), 0);
        check("wr_bus_a5a5_cycles", d(C_A5), 4);
        check("wr_ram2_idle", d(C_EN2), 0);
        check("wr_mem1_5", {16'h0, mem1[5]}, 32'hA5A5);

        // single read from RAM2
        snap();
        op(1'b0, 17'h10005, 16'h0, 16'h1234);
        check("rd_oe2_low_cycles", d(C_OE2), 4);
        check("rd_en2_low_cycles", d(C_EN2), 4);
        check("rd_we2_low_cycles", d(C_WE2), 0);
        check("rd_ram1_idle", d(C_EN1), 0);

        // re and we held together: one write only
        snap();
        begin
            exp_t e;
            @(negedge clk);
            cur_addr = 18'h7;
            we = 1'b1; re = 1'b1; addr = 17'h00007; data_in = 16'h5A5A;
            e.data = last_rd;
            e.cyc  = cyc + 1 + LAT;
            q.push_back(e);
            repeat (10) @(negedge clk);
            check("held_not_rearmed", {31'h0, busy}, 32'h0);
            we = 1'b0; re = 1'b0;
        end
        check("held_one_done", d(C_DONE), 1);
        check("held_we1_low_cycles", d(C_WE1), 2);
        check("held_no_read", d(C_OE1), 0);
        check("held_mem1_7", {16'h0, mem1[7]}, 32'h5A5A);
        op(1'b0, 17'h00007, 16'h0, 16'h5A5A);

        // back-to-back writes to both chips, then read RAM1 back
        for (int i = 0; i < 10; i++) op(1'b1, 17'(i), 16'h3C00 + 16'(i), 16'h0);
        for (int i = 0; i < 10; i++) op(1'b1, 17'h10000 + 17'(i), ~(16'h3C00 + 16'(i)), 16'h0);
        for (int i = 0; i < 10; i++) op(1'b0, 17'(i), 16'h0, 16'h3C00 + 16'(i));
        op(1'b0, 17'h10003, 16'h0, ~16'h3C03);

        // async reset in the middle of a write strobe
        snap();
        issue(1'b1, 17'h00020, 16'hBEEF, 16'h0, 1'b0);
        for (int n = 0; n < 10 && ram1WE; n++) begin
            @(posedge clk); #1;
        end
        check("strobe_reached", {31'h0, ram1WE}, 32'h0);
        #2 rst = 1'b0;
        #1;
        check("arst_strobes", {30'h0, ram1WE, ram1EN}, 32'h3);
        check("arst_bus_z", {31'h0, ram_data1 === 16'hzzzz}, 32'h1);
        check("arst_busy_done", {30'h0, busy, done}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        last_rd = 16'h0;
        repeat (4) @(negedge clk);
        check("arst_no_done", d(C_DONE), 0);
        check("arst_data_out", {16'h0, data_out}, 32'h0);
        op(1'b1, 17'h00021, 16'h1111, 16'h0);
        op(1'b0, 17'h00021, 16'h0, 16'h1111);

        // en dropped during RD_WAIT
        op(1'b1, 17'h00022, 16'h2222, 16'h0);
        snap();
        issue(1'b0, 17'h00022, 16'h0, 16'h0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'h0);
        check("abort_strobes", {30'h0, ram1OE, ram1EN}, 32'h3);
        repeat (3) @(negedge clk);
        check("abort_no_done", d(C_DONE), 0);
        check("abort_data_out", {16'h0, data_out}, 32'h1111);
        en = 1'b1;
        op(1'b0, 17'h00022, 16'h0, 16'h2222);

        check("we_oe_both_low", cnt[C_VIOL], 0);
        check("idle_bus_driven", cnt[C_ZBAD], 0);
        check("addr_unstable", cnt[C_ADR], 0);
        check("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
